pim_reg_bank: RTL

PIM_REG_BANK -- requirements
Module: pim_reg_bank

---
 rtl/pim_reg_bank.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pim_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : pim_reg_bank
// Purpose  : PIM architectural register bank with prioritised per-register
//            load/move/update writes and a forward-copy block-move engine.
// Revision : 1.0
// ============================================================================
module pim_reg_bank #(
    parameter int NREGS = 16,
    parameter int REG_W = 10,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREGS-1:0]         ld_en,
    input  logic [NREGS*REG_W-1:0]   ld_data,
    input  logic [NREGS-1:0]         upd_en,
    input  logic [REG_W-1:0]         upd_step,
    input  logic                     mov_valid,
    output logic                     mov_ready,
    input  logic [IDX_W-1:0]         mov_src,
    input  logic [IDX_W-1:0]         mov_dst,
    input  logic [IDX_W:0]           mov_len,
    output logic                     mov_done,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [REG_W-1:0]         rd_data,
    output logic [NREGS*REG_W-1:0]   reg_flat,
    output logic [NREGS-1:0]         ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } state_t;

    localparam logic [IDX_W:0] c_one = {{IDX_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_src;
    logic [IDX_W-1:0]  r_dst;
    logic [IDX_W:0]    r_len;
    logic [IDX_W:0]    r_k;
    logic [IDX_W:0]    w_k_nxt;
    logic              w_accept;
    logic              w_copy;
    logic              w_last;
    logic [IDX_W-1:0]  w_rd_ptr;
    logic [IDX_W-1:0]  w_wr_ptr;
    logic [REG_W-1:0]  w_mov_val;
    logic [REG_W-1:0]  w_regs [NREGS];

    // Pointers are IDX_W wide so the additions wrap modulo NREGS for free.
    assign w_rd_ptr  = r_src + r_k[IDX_W-1:0];
    assign w_wr_ptr  = r_dst + r_k[IDX_W-1:0];
    assign w_last    = (r_k == (r_len - c_one));
    assign w_mov_val = w_regs[w_rd_ptr];
    assign rd_data   = w_regs[rd_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        w_copy      = 1'b0;
        mov_ready   = 1'b0;
        mov_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mov_ready = 1'b1;
                if (mov_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_COPY;
                    w_k_nxt     = '0;
                end
            end
            ST_COPY: begin
                w_copy = 1'b1;
                if (w_last) begin
                    mov_done    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + c_one;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_accept) begin
                r_src <= mov_src;
                r_dst <= mov_dst;
                r_len <= (mov_len == '0) ? c_one : mov_len;
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [REG_W-1:0] r_val;
        logic             r_ovf_bit;
        logic [REG_W:0]   w_sum;
        logic             w_mov_hit;

        assign w_sum     = {1'b0, r_val} + {1'b0, upd_step};
        assign w_mov_hit = w_copy && (w_wr_ptr == IDX_W'(gi));

        // Load beats a move write, which beats a base update.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_val     <= '0;
                r_ovf_bit <= 1'b0;
            end else if (ld_en[gi]) begin
                r_val     <= ld_data[gi*REG_W +: REG_W];
                r_ovf_bit <= 1'b0;
            end else if (w_mov_hit) begin
                r_val     <= w_mov_val;
                r_ovf_bit <= 1'b0;
            end else if (upd_en[gi]) begin
                r_val <= w_sum[REG_W-1:0];
                if (w_sum[REG_W]) begin
                    r_ovf_bit <= 1'b1;
                end
            end
        end

        assign w_regs[gi]                  = r_val;
        assign reg_flat[gi*REG_W +: REG_W] = r_val;
        assign ovf[gi]                     = r_ovf_bit;
    end

endmodule
`default_nettype wire
